// File: rtl/mem_stage_access_unit_if.sv
// Request/response bus between the MEM stage and the access unit,
// plus the pin bundle toward the byte-addressed data RAM.
interface mem_stage_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic        ram_enable;
  logic        ram_readwrite;
  logic [31:0] ram_address;
  logic [31:0] ram_datain;
  logic [1:0]  ram_size;
  logic [31:0] ram_dataout;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_error, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_error, resp_rdata,
    output ram_enable, ram_readwrite, ram_address, ram_datain, ram_size,
    input  ram_dataout
  );

  modport ram (
    input  ram_enable, ram_readwrite, ram_address, ram_datain, ram_size,
    output ram_dataout
  );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM-stage controller for the data RAM: one request at a time, driven through a
// setup/strobe/capture sequence, with load extension and up-front access checking.
module mem_stage_access_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mem_stage_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, CAPTURE} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state, state_nxt;
  logic        ready;
  logic        accept;
  logic        req_err;
  logic        lat_signed;
  logic        resp_valid_q;
  logic        resp_error_q;
  logic [31:0] resp_rdata_q;
  logic        ram_enable_q;
  logic        ram_readwrite_q;
  logic [31:0] ram_address_q;
  logic [31:0] ram_datain_q;
  logic [1:0]  ram_size_q;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Priority order matters only for readability; any hit rejects the request.
  function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
    logic [32:0] last;
    last = {1'b0, addr} + {30'd0, size_bytes(size)} - 33'd1;
    if (size == 2'b11)                     return 1'b1;
    if (size == 2'b01 && addr[0])          return 1'b1;
    if (size == 2'b10 && addr[1:0] != 0)   return 1'b1;
    return (last >= MEM_LIMIT);
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic is_signed,
                                              input logic [31:0] data);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    byte_s = signed'(data[7:0]);
    half_s = signed'(data[15:0]);
    case (size)
      2'b00:   return is_signed ? 32'(byte_s) : {24'd0, data[7:0]};
      2'b01:   return is_signed ? 32'(half_s) : {16'd0, data[15:0]};
      default: return data;
    endcase
  endfunction

  assign ready   = reset_n && (state == IDLE);
  assign accept  = bus.req_valid && ready;
  assign req_err = access_error(bus.req_size, bus.req_addr);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !req_err) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      resp_valid_q    <= 1'b0;
      resp_error_q    <= 1'b0;
      resp_rdata_q    <= '0;
      ram_enable_q    <= 1'b0;
      ram_readwrite_q <= 1'b0;
      ram_address_q   <= '0;
      ram_datain_q    <= '0;
      ram_size_q      <= 2'b00;
      lat_signed      <= 1'b0;
    end else begin
      state        <= state_nxt;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      ram_enable_q <= (state_nxt == STROBE);
      // Accept edge: rejected requests answer immediately and leave the RAM pins alone.
      if (accept) begin
        if (req_err) begin
          resp_valid_q <= 1'b1;
          resp_error_q <= 1'b1;
          resp_rdata_q <= '0;
        end else begin
          ram_address_q   <= bus.req_addr;
          ram_size_q      <= bus.req_size;
          ram_readwrite_q <= bus.req_write;
          ram_datain_q    <= bus.req_wdata;
          lat_signed      <= bus.req_signed;
        end
      end
      // Capture edge: RAM data has been stable since the strobe.
      if (state == CAPTURE) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= ram_readwrite_q ? 32'd0
                                        : extend_load(ram_size_q, lat_signed, bus.ram_dataout);
      end
    end
  end

  assign bus.req_ready     = ready;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_error    = resp_error_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.ram_enable    = ram_enable_q;
  assign bus.ram_readwrite = ram_readwrite_q;
  assign bus.ram_address   = ram_address_q;
  assign bus.ram_datain    = ram_datain_q;
  assign bus.ram_size      = ram_size_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed and randomized bench for mem_stage_access_unit with a big-endian RAM model
// and a byte-array reference memory.
module tb_mem_stage_access_unit;
  localparam int MEM_BYTES = 256;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   last_wait;

  logic [7:0] ram_mem [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  logic [7:0] ra;

  mem_stage_access_unit_if ifc();

  mem_stage_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on a rising edge while enabled; upper bits
  // of narrow reads carry junk so the extension must ignore them.
  always_comb begin
    ra = ifc.ram_address[7:0];
    case (ifc.ram_size)
      2'b00:   ifc.ram_dataout = {24'hC3C3C3, ram_mem[ra]};
      2'b01:   ifc.ram_dataout = {16'h5A5A, ram_mem[ra], ram_mem[ra + 8'd1]};
      default: ifc.ram_dataout = {ram_mem[ra], ram_mem[ra + 8'd1], ram_mem[ra + 8'd2], ram_mem[ra + 8'd3]};
    endcase
  end

  always @(posedge clk) begin
    if (ifc.ram_enable && ifc.ram_readwrite) begin
      case (ifc.ram_size)
        2'b00: ram_mem[ra] <= ifc.ram_datain[7:0];
        2'b01: begin
          ram_mem[ra]        <= ifc.ram_datain[15:8];
          ram_mem[ra + 8'd1] <= ifc.ram_datain[7:0];
        end
        default: begin
          ram_mem[ra]        <= ifc.ram_datain[31:24];
          ram_mem[ra + 8'd1] <= ifc.ram_datain[23:16];
          ram_mem[ra + 8'd2] <= ifc.ram_datain[15:8];
          ram_mem[ra + 8'd3] <= ifc.ram_datain[7:0];
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int a, input logic [7:0] v);
    ref_mem[a] = v;
    ram_mem[a] <= v;
  endtask

  function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] ad);
    longint n;
    if (sz == 2'b11) return 1'b1;
    n = longint'(1) << sz;
    if ((longint'(ad) % n) != 0) return 1'b1;
    return (longint'(ad) + n > MEM_BYTES);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] ad);
    longint v = 0;
    int n = 1 << sz;
    for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[8'(ad + 32'(i))]);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  // One request: waits for ready, drives for one accept edge, then watches 5 cycles.
  task automatic txn(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] ad, input logic [31:0] wd, input string tag);
    logic [4:0]  en_seq, rv_seq;
    logic        err_seen;
    logic [31:0] rdata_seen, sa, sd, pa, pd;
    logic [1:0]  ss, ps;
    logic        sr, pr;
    bit          exp_err;
    logic [31:0] exp_data;
    int n;
    last_wait = 0;
    while (!ifc.req_ready && last_wait < 10) begin
      @(negedge clk);
      last_wait++;
    end
    check({tag, "_ready"}, 32'(ifc.req_ready), 32'd1);
    exp_err  = ref_err(sz, ad);
    exp_data = (exp_err || wr) ? 32'd0 : ref_load(sz, sg, ad);
    pa = ifc.ram_address; pd = ifc.ram_datain; ps = ifc.ram_size; pr = ifc.ram_readwrite;
    ifc.req_write = wr; ifc.req_size = sz; ifc.req_signed = sg;
    ifc.req_addr = ad; ifc.req_wdata = wd; ifc.req_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.req_write = 1'($urandom); ifc.req_size = 2'($urandom); ifc.req_signed = 1'($urandom);
    ifc.req_addr = $urandom; ifc.req_wdata = $urandom;
    en_seq = '0; rv_seq = '0; err_seen = 1'b0; rdata_seen = 'x;
    sa = '0; sd = '0; ss = '0; sr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      en_seq[k] = ifc.ram_enable;
      rv_seq[k] = ifc.resp_valid;
      if (ifc.resp_valid) begin
        err_seen   = ifc.resp_error;
        rdata_seen = ifc.resp_rdata;
      end
      if (k == 1) begin
        sa = ifc.ram_address; sd = ifc.ram_datain; ss = ifc.ram_size; sr = ifc.ram_readwrite;
      end
    end
    check({tag, "_enable_seq"}, 32'(en_seq), exp_err ? 32'h0 : 32'h2);
    check({tag, "_valid_seq"},  32'(rv_seq), exp_err ? 32'h1 : 32'h8);
    check({tag, "_error"},      32'(err_seen), 32'(exp_err));
    check({tag, "_rdata"},      rdata_seen, exp_data);
    if (exp_err) begin
      check({tag, "_pins_held"}, {ifc.ram_address ^ pa} | {ifc.ram_datain ^ pd}
                                 | 32'({ifc.ram_size, ifc.ram_readwrite} ^ {ps, pr}), 32'd0);
    end else begin
      check({tag, "_addr"}, sa, ad);
      check({tag, "_size_rw"}, 32'({ss, sr}), 32'({sz, wr}));
      if (wr) begin
        check({tag, "_datain"}, sd, wd);
        n = 1 << sz;
        for (int i = 0; i < n; i++) ref_mem[8'(ad + 32'(i))] = 8'(wd >> (8 * (n - 1 - i)));
      end
    end
  endtask

  task automatic drive_load(input logic [1:0] sz, input logic sg, input logic [31:0] ad);
    ifc.req_write = 1'b0; ifc.req_size = sz; ifc.req_signed = sg;
    ifc.req_addr = ad; ifc.req_wdata = $urandom; ifc.req_valid = 1'b1;
  endtask

  initial begin
    logic [1:0]  bsz [3] = '{2'd0, 2'd1, 2'd2};
    logic        bsg [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] bad [3] = '{32'd0, 32'd2, 32'd4};
    logic [1:0]  rsz;
    logic [31:0] rad;

    for (int i = 0; i < MEM_BYTES; i++) set_byte(i, 8'($urandom));
    set_byte(0, 8'h85);
    set_byte(2, 8'hFF); set_byte(3, 8'hD3);
    set_byte(4, 8'h7E); set_byte(5, 8'h12); set_byte(6, 8'hF0); set_byte(7, 8'h85);

    // Reset held with a pending request that must not be taken.
    reset_n = 1'b0;
    drive_load(2'b00, 1'b1, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     32'(ifc.req_ready), 32'd0);
    check("rst_resp_vld",  32'(ifc.resp_valid), 32'd0);
    check("rst_resp_err",  32'(ifc.resp_error), 32'd0);
    check("rst_rdata",     ifc.resp_rdata, 32'd0);
    check("rst_enable",    32'(ifc.ram_enable), 32'd0);
    check("rst_rw",        32'(ifc.ram_readwrite), 32'd0);
    check("rst_addr",      ifc.ram_address, 32'd0);
    check("rst_datain",    ifc.ram_datain, 32'd0);
    check("rst_size",      32'(ifc.ram_size), 32'd0);
    reset_n = 1'b1;
    #1;
    txn(1'b0, 2'b00, 1'b1, 32'd0, 32'd0, "ld_b_s");
    check("first_accept_wait", 32'(last_wait), 32'd0);
    check("ld_b_s_value", ifc.resp_rdata, 32'hFFFFFF85);

    txn(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, "ld_b_u");
    check("ld_b_u_value", ifc.resp_rdata, 32'h00000085);
    txn(1'b0, 2'b01, 1'b1, 32'd2, 32'd0, "ld_h_s");
    check("ld_h_s_value", ifc.resp_rdata, 32'hFFFFFFD3);
    txn(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, "ld_w");
    check("ld_w_value", ifc.resp_rdata, 32'h7E12F085);
    txn(1'b1, 2'b10, 1'b1, 32'd8, 32'hE35D8AC5, "st_w");
    txn(1'b0, 2'b10, 1'b1, 32'd8, 32'd0, "ld_w_back");
    check("ld_w_back_value", ifc.resp_rdata, 32'hE35D8AC5);

    txn(1'b0, 2'b10, 1'b0, 32'd6,   32'd0, "err_w_mis");
    txn(1'b1, 2'b01, 1'b0, 32'd3,   32'h1234, "err_h_mis");
    txn(1'b0, 2'b11, 1'b0, 32'd0,   32'd0, "err_size");
    txn(1'b0, 2'b10, 1'b0, 32'd252, 32'd0, "ok_w_252");
    txn(1'b1, 2'b10, 1'b0, 32'd254, 32'hFFFF, "err_w_range");
    txn(1'b0, 2'b00, 1'b0, 32'd256, 32'd0, "err_b_range");

    // Back-to-back loads with req_valid held: accepts every 4th edge.
    @(negedge clk);
    for (int k = 0; k <= 12; k++) begin
      check("b2b_ready", 32'(ifc.req_ready), 32'((k % 4) == 0));
      check("b2b_resp",  32'(ifc.resp_valid), 32'(k > 0 && (k % 4) == 0));
      if (k > 0 && (k % 4) == 0)
        check("b2b_rdata", ifc.resp_rdata, ref_load(bsz[k/4-1], bsg[k/4-1], bad[k/4-1]));
      if ((k % 4) == 0 && k < 12) drive_load(bsz[k/4], bsg[k/4], bad[k/4]);
      else if (k == 12) ifc.req_valid = 1'b0;
      @(negedge clk);
    end

    // Reset pulse during the strobe of an in-flight load.
    drive_load(2'b10, 1'b0, 32'd4);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(negedge clk);
    check("abort_strobe", 32'(ifc.ram_enable), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_enable", 32'(ifc.ram_enable), 32'd0);
    check("abort_resp",   32'(ifc.resp_valid), 32'd0);
    check("abort_ready",  32'(ifc.req_ready), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(ifc.resp_valid), 32'd0);
    end

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      rsz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rad = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 259));
      txn(1'($urandom), rsz, 1'($urandom), rad, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_access_unit.md
# mem_stage_access_unit

Pipeline-side controller for the byte-addressed data RAM (`data_ram256x8`). Accepts one load/store request at a time from the MEM stage and drives the RAM's Enable/ReadWrite/Address/DataIn/Size pins in a fixed setup–strobe–release sequence. Zero- or sign-extends load data and returns a single-cycle response. Rejects misaligned or out-of-range accesses without touching the RAM.

## Interface
- `MEM_BYTES`, 256: RAM capacity in bytes; any address `>= MEM_BYTES` is out of range.
- `clk`  in  1  single clock, all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  MEM stage presents a request.
- `req_ready`  out  1  unit can accept; 1 only in IDLE with `reset_n`=1.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_error`  out  1  qualified by `resp_valid`: misaligned, reserved size, or out of range.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `ram_enable`  out  1  to RAM Enable.
- `ram_readwrite`  out  1  to RAM ReadWrite (1 = write).
- `ram_address`  out  32  to RAM Address.
- `ram_datain`  out  32  to RAM DataIn.
- `ram_size`  out  2  to RAM Size.
- `ram_dataout`  in  32  from RAM DataOut; byte in [7:0], halfword in [15:0].

## Operation
- FSM states: IDLE, SETUP, STROBE, CAPTURE.
- Accept: `req_valid && req_ready` at a rising edge. All request fields latch on that edge.
- Error check at accept, in this priority:
  - `req_size`=11 → error.
  - Halfword with `addr[0]`≠0 → error.
  - Word with `addr[1:0]`≠0 → error.
  - `addr + bytes - 1 >= MEM_BYTES` → error.
- Erroring request: FSM stays in IDLE; `resp_valid`=1, `resp_error`=1, `resp_rdata`=0 next cycle; no RAM pins change.
- Good request path: IDLE→SETUP→STROBE→CAPTURE→IDLE.
  - SETUP: `ram_address`, `ram_size`, `ram_readwrite`, `ram_datain` driven from the latch; `ram_enable`=0.
  - STROBE: `ram_enable`=1; all other RAM pins held.
  - CAPTURE: `ram_enable`=0; pins held.
  - On the CAPTURE→IDLE edge, `resp_rdata` registers the extended `ram_dataout`; `resp_valid`=1, `resp_error`=0.
- Load extension:
  - Byte: [7:0], bit 7 replicated if signed.
  - Halfword: [15:0], bit 15 replicated if signed.
  - Word: passthrough; `req_signed` ignored.
- Stores: `ram_datain` = `req_wdata` unmodified; `resp_rdata`=0.
- RAM pins keep their last values while IDLE; only `ram_enable` is guaranteed 0.

## Timing
- Reset (`reset_n`=0 at an edge): FSM→IDLE; `resp_valid`, `resp_error`, `ram_enable`, `ram_readwrite` = 0; `resp_rdata`, `ram_address`, `ram_datain` = 0; `ram_size`=00.
- `req_ready`=0 while `reset_n`=0.
- Reset mid-operation aborts: `ram_enable` is low the cycle after the reset edge, and no response is issued for the aborted request.
- Good access, accepted at edge E0:
  - SETUP during E0–E1.
  - `ram_enable` high exactly during E1–E2.
  - CAPTURE during E2–E3.
  - `resp_valid` high during E3–E4.
- Error accepted at E0: `resp_valid` during E0–E1.
- `req_ready` is 1 in the same cycle as `resp_valid`, so the next request can be accepted at E4 (good) or E1 (error). Peak throughput is one RAM access per 4 cycles.
- `resp_valid` is never high for two consecutive cycles from the same request.
- `req_*` changes outside the accept edge are ignored.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `req_valid`=1 → all outputs 0, `req_ready`=0, no accept; first accept on the first edge after release.
- Byte loads: RAM model returns `ram_dataout[7:0]`=0x85 for addr 0.
  - `req_signed`=1 → `resp_rdata`=0xFFFFFF85.
  - `req_signed`=0 → 0x00000085.
  - `resp_valid` exactly 3 cycles after accept; `ram_enable` high exactly 1 cycle.
- Halfword load, addr 2, `[15:0]`=0xFFD3, signed → 0xFFFFFFD3. Unsigned word load, addr 4, 0x7E12F085 → 0x7E12F085.
- Word store 0xE35D8AC5 to addr 8 → during STROBE, `ram_readwrite`=1, `ram_size`=10, `ram_address`=8, `ram_datain`=0xE35D8AC5; then `resp_rdata`=0, `resp_error`=0.
- Errors, each with `ram_enable` staying 0 and `resp_error`=1 one cycle after accept:
  - Word at addr 6.
  - Halfword at addr 3.
  - Size 11.
  - Word at addr 254 with `MEM_BYTES`=256.
- Back-to-back: `req_valid` held high with 3 good requests → accepts at E0, E4, E8; pass a reset pulse during the second request's STROBE → `ram_enable` low next cycle, no response for it.
